mips_fetch_unit: RTL and testbench

- Parametrised instruction-fetch engine for the multicycle MIPS core.
- Assembles one 32-bit instruction from a memory bus of configurable width, BUSW/8 bytes per beat, over 32/BUSW beats.
- Supports memory wait states through a req/ready handshake, and owns the PC and the instruction register.
- Sits between the FSM controller (start/done) and the memory port; replaces the fixed four-cycle byte fetch and per-byte IR write enables.

---
 rtl/mips_fetch_unit_if.sv | 30 +++
 rtl/mips_fetch_unit.sv | 107 ++++++++++
 tb/tb_mips_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bundle: controller start/done and redirect, memory req/ready beat port, PC/IR view.
// master = fetch unit side, slave = controller plus memory side.
interface mips_fetch_unit_if #(
  parameter int WIDTH = 8,
  parameter int BUSW  = 8
);
  logic             start;
  logic             pc_load;
  logic [WIDTH-1:0] pc_next;
  logic             flush;
  logic [BUSW-1:0]  mem_rdata;
  logic             mem_ready;
  logic             mem_req;
  logic [WIDTH-1:0] mem_adr;
  logic [WIDTH-1:0] pc;
  logic [31:0]      instr;
  logic             busy;
  logic             done;
  logic             fault;

  modport master (
    input  start, pc_load, pc_next, flush, mem_rdata, mem_ready,
    output mem_req, mem_adr, pc, instr, busy, done, fault
  );

  modport slave (
    output start, pc_load, pc_next, flush, mem_rdata, mem_ready,
    input  mem_req, mem_adr, pc, instr, busy, done, fault
  );
endinterface

// File: rtl/mips_fetch_unit.sv
// Multi-beat instruction fetch owning PC and IR; ALIGN_CHECK_EN adds a misaligned-start fault.
// Latency BEATS+1 cycles from start to done plus one per mem_ready-low cycle; waits hold all state.
module mips_fetch_unit #(
  parameter int WIDTH = 8,
  parameter int BUSW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  mips_fetch_unit_if.master bus
);
  localparam int BEATS = 32 / BUSW;
  localparam int STEP  = BUSW / 8;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    beat_cnt;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] start_pc;
  logic [31:0]      instr_q;
  logic             mem_req_q;
  logic             busy_q;
  logic             done_q;
  logic             fault_q;
  logic [WIDTH-1:0] eff_pc;
  logic             misaligned;

  // A same-cycle pc_load redirects the fetch that start launches.
  assign eff_pc = bus.pc_load ? bus.pc_next : pc_q;

`ifdef ALIGN_CHECK_EN
  assign misaligned = |eff_pc[1:0];
`else
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      pc_q      <= '0;
      start_pc  <= '0;
      instr_q   <= '0;
      mem_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      fault_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.pc_load) pc_q <= bus.pc_next;
          if (bus.start) begin
            if (misaligned) begin
              fault_q <= 1'b1;
            end else begin
              start_pc  <= eff_pc;
              beat_cnt  <= '0;
              state     <= FETCH;
              mem_req_q <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end
        FETCH: begin
          // flush beats a coincident mem_ready: the beat is dropped and PC rewinds.
          if (bus.flush) begin
            state     <= IDLE;
            pc_q      <= start_pc;
            beat_cnt  <= '0;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (bus.mem_ready) begin
            instr_q[beat_cnt*BUSW +: BUSW] <= bus.mem_rdata;
            pc_q     <= pc_q + WIDTH'(STEP);
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == CW'(BEATS - 1)) begin
              state     <= DONE;
              mem_req_q <= 1'b0;
              done_q    <= 1'b1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          mem_req_q <= 1'b0;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req = mem_req_q;
  assign bus.mem_adr = pc_q;
  assign bus.pc      = pc_q;
  assign bus.instr   = instr_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.fault   = fault_q;
endmodule

// File: tb/tb_mips_fetch_unit.sv
// Three fetch units (BUSW 8/16/32) share one controller stimulus and a byte memory;
// each is compared every cycle with a transaction-level model of the fetch rules.
module tb_mips_fetch_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       pc_load;
  logic [7:0] pc_next;
  logic       flush;
  logic       mem_ready;
  logic [7:0] mem [256];
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  mips_fetch_unit_if #(.WIDTH(8), .BUSW(8))  if8  ();
  mips_fetch_unit_if #(.WIDTH(8), .BUSW(16)) if16 ();
  mips_fetch_unit_if #(.WIDTH(8), .BUSW(32)) if32 ();

  mips_fetch_unit #(.WIDTH(8), .BUSW(8))  u8  (.clk(clk), .reset(reset), .bus(if8));
  mips_fetch_unit #(.WIDTH(8), .BUSW(16)) u16 (.clk(clk), .reset(reset), .bus(if16));
  mips_fetch_unit #(.WIDTH(8), .BUSW(32)) u32 (.clk(clk), .reset(reset), .bus(if32));

  assign if8.start  = start;   assign if16.start  = start;   assign if32.start  = start;
  assign if8.pc_load = pc_load; assign if16.pc_load = pc_load; assign if32.pc_load = pc_load;
  assign if8.pc_next = pc_next; assign if16.pc_next = pc_next; assign if32.pc_next = pc_next;
  assign if8.flush  = flush;   assign if16.flush  = flush;   assign if32.flush  = flush;
  assign if8.mem_ready = mem_ready; assign if16.mem_ready = mem_ready; assign if32.mem_ready = mem_ready;

  // Little-endian byte memory: lowest address in the low byte of each beat.
  assign if8.mem_rdata  = mem[if8.mem_adr];
  assign if16.mem_rdata = {mem[8'(if16.mem_adr + 8'd1)], mem[if16.mem_adr]};
  assign if32.mem_rdata = {mem[8'(if32.mem_adr + 8'd3)], mem[8'(if32.mem_adr + 8'd2)],
                           mem[8'(if32.mem_adr + 8'd1)], mem[if32.mem_adr]};

  typedef struct packed {
    logic        req;
    logic [7:0]  adr;
    logic [7:0]  pc;
    logic [31:0] instr;
    logic        busy;
    logic        done;
    logic        fault;
  } obs_t;

  obs_t obs [3];
  assign obs[0] = {if8.mem_req,  if8.mem_adr,  if8.pc,  if8.instr,  if8.busy,  if8.done,  if8.fault};
  assign obs[1] = {if16.mem_req, if16.mem_adr, if16.pc, if16.instr, if16.busy, if16.done, if16.fault};
  assign obs[2] = {if32.mem_req, if32.mem_adr, if32.pc, if32.instr, if32.busy, if32.done, if32.fault};

  localparam int STEPS [3] = '{1, 2, 4};

  // Model: 0 idle, 1 fetching, 2 done pulse. A fetch ends once pc has moved 4 bytes past its start.
  int          m_st    [3];
  logic [7:0]  m_pc    [3];
  logic [7:0]  m_spc   [3];
  logic [31:0] m_instr [3];
  bit          m_ivld  [3];
  bit          m_fault [3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd32(input logic [7:0] a);
    return {mem[8'(a + 8'd3)], mem[8'(a + 8'd2)], mem[8'(a + 8'd1)], mem[a]};
  endfunction

  task automatic model_step();
    logic [7:0] eff;
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        m_st[k] = 0; m_pc[k] = 8'd0; m_spc[k] = 8'd0;
        m_instr[k] = 32'd0; m_ivld[k] = 1'b1; m_fault[k] = 1'b0;
      end else begin
        m_fault[k] = 1'b0;
        case (m_st[k])
          0: begin
            eff = pc_load ? pc_next : m_pc[k];
            m_pc[k] = eff;
            if (start) begin
`ifdef ALIGN_CHECK_EN
              if (eff[1:0] != 2'd0) m_fault[k] = 1'b1;
              else
`endif
              begin
                m_spc[k] = eff;
                m_st[k]  = 1;
              end
            end
          end
          1: begin
            if (flush) begin
              m_st[k] = 0;
              m_pc[k] = m_spc[k];
            end else if (mem_ready) begin
              m_ivld[k] = 1'b0;
              m_pc[k]   = m_pc[k] + 8'(STEPS[k]);
              if (m_pc[k] == 8'(m_spc[k] + 8'd4)) begin
                m_st[k]    = 2;
                m_instr[k] = rd32(m_spc[k]);
                m_ivld[k]  = 1'b1;
              end
            end
          end
          default: m_st[k] = 0;
        endcase
      end
    end
  endtask

  task automatic check_all();
    string s;
    for (int k = 0; k < 3; k++) begin
      s = $sformatf("w%0d", 8 * STEPS[k]);
      chk({s, ".mem_req"}, 32'(obs[k].req),   32'(m_st[k] == 1));
      chk({s, ".busy"},    32'(obs[k].busy),  32'(m_st[k] != 0));
      chk({s, ".done"},    32'(obs[k].done),  32'(m_st[k] == 2));
      chk({s, ".fault"},   32'(obs[k].fault), 32'(m_fault[k]));
      chk({s, ".pc"},      32'(obs[k].pc),    32'(m_pc[k]));
      if (m_st[k] == 1) chk({s, ".mem_adr"}, 32'(obs[k].adr), 32'(m_pc[k]));
      if (m_ivld[k])    chk({s, ".instr"},   obs[k].instr,    m_instr[k]);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic drain();
    start = 1'b0; pc_load = 1'b0; flush = 1'b0; mem_ready = 1'b1; reset = 1'b0;
    for (int i = 0; i < 12 && (obs[0].busy || obs[1].busy || obs[2].busy); i++) tick();
    chk("drain_idle", 32'({obs[0].busy, obs[1].busy, obs[2].busy}), 32'd0);
  endtask

  task automatic load_pc(input logic [7:0] v);
    pc_load = 1'b1; pc_next = v;
    tick();
    pc_load = 1'b0;
  endtask

  initial begin
    int dones;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h20; mem[1] = 8'h03; mem[2] = 8'h04; mem[3] = 8'hA0;
    mem[8] = 8'h34; mem[9] = 8'h12; mem[10] = 8'hCD; mem[11] = 8'hAB;

    reset = 1'b1; start = 1'b0; pc_load = 1'b0; pc_next = 8'd0; flush = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    // Byte fetch from 0 with no wait states.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("basic_adr", 32'(obs[0].adr), i);
      tick();
    end
    chk("basic_done", 32'(obs[0].done), 32'd1);
    chk("basic_instr", obs[0].instr, 32'hA0040320);
    chk("basic_pc", 32'(obs[0].pc), 32'd4);
    tick();
    chk("basic_idle", 32'(obs[0].busy), 32'd0);
    drain();

    // Halfword fetch from 8 with two wait cycles before each beat.
    load_pc(8'd8);
    start = 1'b1; mem_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      chk("wait_adr", 32'(obs[1].adr), (t <= 3) ? 32'd8 : 32'd10);
      mem_ready = (t == 3 || t == 6);
      tick();
    end
    chk("wait_done", 32'(obs[1].done), 32'd1);
    chk("wait_instr", obs[1].instr, 32'hABCD1234);
    chk("wait_pc", 32'(obs[1].pc), 32'd12);
    drain();

    // start together with pc_load fetches from the new PC.
    load_pc(8'd4);
    start = 1'b1; pc_load = 1'b1; pc_next = 8'h40; mem_ready = 1'b1;
    tick();
    start = 1'b0; pc_load = 1'b0;
    for (int k = 0; k < 3; k++) chk("redir_adr", 32'(obs[k].adr), 32'h40);
    drain();
    for (int k = 0; k < 3; k++) chk("redir_pc", 32'(obs[k].pc), 32'h44);

    // Flush coinciding with the third byte beat.
    load_pc(8'h10);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 32'(obs[0].busy), 32'd0);
    chk("flush_pc", 32'(obs[0].pc), 32'h10);
    chk("flush_done", 32'(obs[0].done), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("flush_refetch", 32'(obs[0].adr), 32'h10);
    drain();

    // Word fetch at 0xFC wraps; start held high is taken only from idle.
    load_pc(8'hFC);
    start = 1'b1; mem_ready = 1'b1;
    dones = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      dones += int'(obs[2].done);
      if (i == 2) chk("wrap_pc", 32'(obs[2].pc), 32'd0);
    end
    chk("wrap_dones", dones, 32'd3);
    drain();

    // Reset during the second byte beat.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_pc", 32'(obs[0].pc), 32'd0);
    chk("rst_instr", obs[0].instr, 32'd0);
    chk("rst_req", 32'(obs[0].req), 32'd0);
    drain();

    // Start at a misaligned PC.
    load_pc(8'h02);
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef ALIGN_CHECK_EN
    chk("align_fault", 32'(obs[0].fault), 32'd1);
    chk("align_req", 32'(obs[0].req), 32'd0);
    chk("align_pc", 32'(obs[0].pc), 32'h02);
`else
    chk("align_req", 32'(obs[0].req), 32'd1);
    chk("align_adr", 32'(obs[0].adr), 32'h02);
`endif
    drain();

    // Random controller and memory behaviour.
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 9) < 4);
      pc_load   = ($urandom_range(0, 9) < 2);
      pc_next   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {6'($urandom), 2'b00};
      flush     = ($urandom_range(0, 19) == 0);
      mem_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
